// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes opcode/funct into the ALU control word
// and latches operands, with stall (hold) and flush (bubble) from hazard unit.
module id_ex_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   input  logic [4:0]   shamt,
   input  logic [15:0]  imm,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] rt_data,
   input  logic [4:0]   rt_addr,
   input  logic [4:0]   rd_addr,
   input  logic         stall,
   input  logic         flush,
   output logic         out_valid,
   output logic [N-1:0] alu_in1,
   output logic [N-1:0] alu_in2,
   output logic [5:0]   alu_op,
   output logic [4:0]   dest_addr,
   output logic         reg_write,
   output logic         mem_read,
   output logic         mem_write,
   output logic [N-1:0] store_data,
   output logic         illegal
);

   typedef struct packed {
      logic         valid;
      logic [N-1:0] in1;
      logic [N-1:0] in2;
      logic [5:0]   op;
      logic [4:0]   dest;
      logic         we;
      logic         mr;
      logic         mw;
      logic [N-1:0] sd;
      logic         ill;
   } ex_t;

   localparam ex_t BUBBLE = '{
      valid: 1'b0,
      in1:   '0,
      in2:   '0,
      op:    6'b100000,
      dest:  5'd0,
      we:    1'b0,
      mr:    1'b0,
      mw:    1'b0,
      sd:    '0,
      ill:   1'b0
   };

   ex_t q;
   ex_t nx;

   logic [N-1:0] sext;
   logic [N-1:0] zext;
   logic [N-1:0] shz;

   logic r_alu;
   logic r_shf;
   logic op_addi;
   logic op_logi;
   logic op_lw;
   logic op_sw;
   logic op_beq;

   assign sext = {{(N-16){imm[15]}}, imm};
   assign zext = {{(N-16){1'b0}}, imm};
   assign shz  = {{(N-5){1'b0}}, shamt};

   always_comb begin
      r_alu   = 1'b0;
      r_shf   = 1'b0;
      if (opcode == 6'b000000) begin
         r_alu = funct inside {6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b100110, 6'b100111};
         r_shf = funct inside {6'b000010, 6'b000011};
      end
      op_addi = opcode == 6'b001000;
      op_logi = opcode inside {6'b001100, 6'b001101, 6'b001110};
      op_lw   = opcode == 6'b100011;
      op_sw   = opcode == 6'b101011;
      op_beq  = opcode == 6'b000100;
   end

   always_comb begin
      nx = BUBBLE;
      if (in_valid) begin
         nx.valid = 1'b1;
         nx.sd    = rt_data;
         nx.in1   = rs_data;
         unique case (1'b1)
            r_alu: begin
               nx.op   = funct;
               nx.in2  = rt_data;
               nx.dest = rd_addr;
               nx.we   = 1'b1;
            end
            r_shf: begin
               nx.op   = funct;
               nx.in1  = rt_data;
               nx.in2  = shz;
               nx.dest = rd_addr;
               nx.we   = 1'b1;
            end
            op_addi: begin
               nx.in2  = sext;
               nx.dest = rt_addr;
               nx.we   = 1'b1;
            end
            op_logi: begin
               // andi/ori/xori low opcode bits line up with and/or/xor funct
               nx.op   = {4'b1001, opcode[1:0]};
               nx.in2  = zext;
               nx.dest = rt_addr;
               nx.we   = 1'b1;
            end
            op_lw: begin
               nx.in2  = sext;
               nx.dest = rt_addr;
               nx.mr   = 1'b1;
               nx.we   = 1'b1;
            end
            op_sw: begin
               nx.in2  = sext;
               nx.mw   = 1'b1;
            end
            op_beq: begin
               nx.op   = 6'b100010;
               nx.in2  = rt_data;
            end
            default: begin
               nx     = BUBBLE;
               nx.ill = 1'b1;
            end
         endcase
         if (nx.dest == 5'd0) nx.we = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       q <= BUBBLE;
      else if (flush)  q <= BUBBLE;
      else if (!stall) q <= nx;
   end

   assign out_valid  = q.valid;
   assign alu_in1    = q.in1;
   assign alu_in2    = q.in2;
   assign alu_op     = q.op;
   assign dest_addr  = q.dest;
   assign reg_write  = q.we;
   assign mem_read   = q.mr;
   assign mem_write  = q.mw;
   assign store_data = q.sd;
   assign illegal    = q.ill;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, extension, stall/flush,
// illegal handling and asynchronous reset.
module tb_id_ex_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [4:0]  rt_addr;
   logic [4:0]  rd_addr;
   logic        stall;
   logic        flush;
   logic        out_valid;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [5:0]  alu_op;
   logic [4:0]  dest_addr;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] store_data;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.N(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .opcode     (opcode),
      .funct      (funct),
      .shamt      (shamt),
      .imm        (imm),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .rt_addr    (rt_addr),
      .rd_addr    (rd_addr),
      .stall      (stall),
      .flush      (flush),
      .out_valid  (out_valid),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_op     (alu_op),
      .dest_addr  (dest_addr),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .store_data (store_data),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [15:0] im,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] ra, input logic [4:0] rd);
      in_valid = 1'b1;
      opcode   = op;
      funct    = fn;
      shamt    = sh;
      imm      = im;
      rs_data  = rs;
      rt_data  = rt;
      rt_addr  = ra;
      rd_addr  = rd;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      opcode   = '0;
      funct    = '0;
      shamt    = '0;
      imm      = '0;
      rs_data  = '0;
      rt_data  = '0;
      rt_addr  = '0;
      rd_addr  = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_op", {26'd0, alu_op}, 32'h20);
      chk("rst_in1", alu_in1, 32'd0);
      chk("rst_ill", {31'd0, illegal}, 32'd0);

      // sub
      drive(6'b000000, 6'b100010, 5'd0, 16'h0, 32'd7, 32'd3, 5'd0, 5'd5);
      tick();
      chk("sub_op", {26'd0, alu_op}, 32'h22);
      chk("sub_in1", alu_in1, 32'd7);
      chk("sub_in2", alu_in2, 32'd3);
      chk("sub_dest", {27'd0, dest_addr}, 32'd5);
      chk("sub_we", {31'd0, reg_write}, 32'd1);
      chk("sub_valid", {31'd0, out_valid}, 32'd1);
      chk("sub_sd", store_data, 32'd3);

      // addi sign extension
      drive(6'b001000, 6'b000000, 5'd0, 16'hFFFE, 32'd10, 32'd0, 5'd9, 5'd0);
      tick();
      chk("addi_in2", alu_in2, 32'hFFFFFFFE);
      chk("addi_op", {26'd0, alu_op}, 32'h20);
      chk("addi_dest", {27'd0, dest_addr}, 32'd9);
      chk("addi_we", {31'd0, reg_write}, 32'd1);

      // ori zero extension
      drive(6'b001101, 6'b000000, 5'd0, 16'hFFFE, 32'd10, 32'd0, 5'd9, 5'd0);
      tick();
      chk("ori_in2", alu_in2, 32'h0000FFFE);
      chk("ori_op", {26'd0, alu_op}, 32'h25);

      // sra
      drive(6'b000000, 6'b000011, 5'd4, 16'h0, 32'd1, 32'h80000000,
            5'd0, 5'd6);
      tick();
      chk("sra_in1", alu_in1, 32'h80000000);
      chk("sra_in2", alu_in2, 32'd4);
      chk("sra_op", {26'd0, alu_op}, 32'h03);
      chk("sra_dest", {27'd0, dest_addr}, 32'd6);

      // lw then stall with changing inputs
      drive(6'b100011, 6'b000000, 5'd0, 16'h0004, 32'h64, 32'h55, 5'd8, 5'd0);
      tick();
      chk("lw_in1", alu_in1, 32'h64);
      chk("lw_in2", alu_in2, 32'd4);
      chk("lw_mr", {31'd0, mem_read}, 32'd1);
      chk("lw_dest", {27'd0, dest_addr}, 32'd8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(6'b101011, 6'b100000, 5'(i), 16'(i + 100), 32'(i + 7),
               32'(i + 9), 5'(i + 1), 5'(i + 2));
         tick();
         chk("stall_mr", {31'd0, mem_read}, 32'd1);
         chk("stall_dest", {27'd0, dest_addr}, 32'd8);
         chk("stall_in2", alu_in2, 32'd4);
         chk("stall_mw", {31'd0, mem_write}, 32'd0);
      end
      flush = 1'b1;
      tick();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_mr", {31'd0, mem_read}, 32'd0);
      chk("flush_op", {26'd0, alu_op}, 32'h20);
      chk("flush_sd", store_data, 32'd0);
      flush = 1'b0;
      stall = 1'b0;

      // illegal opcode, held through stall
      drive(6'b111111, 6'b100000, 5'd0, 16'h1234, 32'd1, 32'd2, 5'd3, 5'd4);
      tick();
      chk("ill_set", {31'd0, illegal}, 32'd1);
      chk("ill_valid", {31'd0, out_valid}, 32'd0);
      chk("ill_op", {26'd0, alu_op}, 32'h20);
      chk("ill_in1", alu_in1, 32'd0);
      stall = 1'b1;
      drive(6'b000000, 6'b100000, 5'd0, 16'h0, 32'd1, 32'd2, 5'd0, 5'd0);
      tick();
      chk("ill_hold", {31'd0, illegal}, 32'd1);
      stall = 1'b0;

      // add to r0
      tick();
      chk("r0_ill", {31'd0, illegal}, 32'd0);
      chk("r0_we", {31'd0, reg_write}, 32'd0);
      chk("r0_valid", {31'd0, out_valid}, 32'd1);
      chk("r0_in1", alu_in1, 32'd1);

      // sw
      drive(6'b101011, 6'b000000, 5'd0, 16'h0008, 32'h1000, 32'hABCD,
            5'd7, 5'd0);
      tick();
      chk("sw_mw", {31'd0, mem_write}, 32'd1);
      chk("sw_we", {31'd0, reg_write}, 32'd0);
      chk("sw_dest", {27'd0, dest_addr}, 32'd0);
      chk("sw_sd", store_data, 32'hABCD);
      chk("sw_in2", alu_in2, 32'd8);

      // beq
      drive(6'b000100, 6'b000000, 5'd0, 16'h0010, 32'd5, 32'd6, 5'd7, 5'd0);
      tick();
      chk("beq_op", {26'd0, alu_op}, 32'h22);
      chk("beq_in2", alu_in2, 32'd6);
      chk("beq_we", {31'd0, reg_write}, 32'd0);
      chk("beq_dest", {27'd0, dest_addr}, 32'd0);

      // R-type funct 000000 is illegal
      drive(6'b000000, 6'b000000, 5'd1, 16'h0, 32'd5, 32'd6, 5'd7, 5'd8);
      tick();
      chk("sll_ill", {31'd0, illegal}, 32'd1);
      chk("sll_valid", {31'd0, out_valid}, 32'd0);

      // in_valid=0 loads a bubble
      in_valid = 1'b0;
      tick();
      chk("nv_valid", {31'd0, out_valid}, 32'd0);
      chk("nv_ill", {31'd0, illegal}, 32'd0);

      // asynchronous reset while stalled
      drive(6'b000000, 6'b100000, 5'd0, 16'h0, 32'd11, 32'd12, 5'd0, 5'd3);
      tick();
      chk("pre_valid", {31'd0, out_valid}, 32'd1);
      stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_op", {26'd0, alu_op}, 32'h20);
      chk("arst_in1", alu_in1, 32'd0);
      chk("arst_we", {31'd0, reg_write}, 32'd0);
      chk("arst_dest", {27'd0, dest_addr}, 32'd0);
      tick();
      reset = 1'b0;
      stall = 1'b0;
      tick();
      chk("post_valid", {31'd0, out_valid}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Registered ID/EX pipeline stage that feeds the EX-stage ALU.
- Latches decoded-instruction fields and register-file operands each cycle.
- Translates MIPS opcode/funct into the ALU's 6-bit operation code and selects the ALU operands.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- N, 32: datapath width of operands and immediates after extension.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ID holds a real instruction this cycle
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- shamt  in  5  instruction[10:6]
- imm  in  16  instruction[15:0]
- rs_data  in  N  register file read port A
- rt_data  in  N  register file read port B
- rt_addr  in  5  instruction[20:16]
- rd_addr  in  5  instruction[15:11]
- stall  in  1  hold all outputs
- flush  in  1  replace the stage contents with a bubble
- out_valid  out  1  EX holds a real instruction
- alu_in1  out  N  ALU input1
- alu_in2  out  N  ALU input2
- alu_op  out  6  ALU operation code
- dest_addr  out  5  writeback register
- reg_write  out  1  writeback enable
- mem_read  out  1  load
- mem_write  out  1  store
- store_data  out  N  store value (rt_data)
- illegal  out  1  last loaded instruction was undecodable

Behaviour:
- All outputs are registered and update on posedge clk. Latency is 1 cycle from ID inputs to outputs.
- Update priority per edge: reset > flush > stall > load.
- Reset (asynchronous, immediate) and flush both produce the bubble state:
  - out_valid=0, reg_write=0, mem_read=0, mem_write=0, illegal=0.
  - alu_op=6'b100000; alu_in1, alu_in2, store_data and dest_addr all 0.
- Reset asserted mid-stall clears the stage regardless of stall.
- Stall=1 with flush=0: every output holds its value, including illegal.
- Flush=1 with stall=1: flush wins and the bubble is loaded.
- Load with in_valid=0: bubble loaded.
- Load with in_valid=1: decode as below. out_valid=1 and illegal=0 unless noted.
- R-type (opcode 000000):
  - funct 100000/100010/100100/100101/100110/100111: alu_op=funct, in1=rs_data, in2=rt_data, dest=rd_addr, reg_write=1.
  - funct 000010 (srl) / 000011 (sra): alu_op=funct, in1=rt_data, in2=zero-extended shamt, dest=rd_addr, reg_write=1.
  - Any other funct, including 000000: illegal case.
- addi 001000: alu_op=100000, in2=sign-extended imm, in1=rs_data, dest=rt_addr, reg_write=1.
- andi 001100 / ori 001101 / xori 001110: alu_op=100100/100101/100110 respectively, in2=zero-extended imm, in1=rs_data, dest=rt_addr, reg_write=1.
- lw 100011: alu_op=100000, in1=rs_data, in2=sign-extended imm, dest=rt_addr, mem_read=1, reg_write=1.
- sw 101011: alu_op=100000, in1=rs_data, in2=sign-extended imm, mem_write=1, store_data=rt_data, reg_write=0, dest=0.
- beq 000100: alu_op=100010, in1=rs_data, in2=rt_data, reg_write=0, dest=0. The branch decision is made downstream from ALU zero.
- store_data=rt_data for every valid load, not only sw.
- Illegal case: bubble contents, but illegal=1. illegal stays set until the next non-stalled load, flush, or reset.
- dest_addr==0 forces reg_write=0. out_valid remains 1.
- Sign extension replicates imm[15] into bits N-1..16. Zero extension fills with 0.

Test Plan:
- Reset mid-run: reset=1 asynchronously while stall=1 and outputs valid -> outputs go to the bubble state without waiting for a clock edge; alu_op=6'b100000.
- R-type sub: opcode=0, funct=100010, rs_data=7, rt_data=3, rd_addr=5, in_valid=1 -> after 1 edge:
  - alu_op=100010, alu_in1=7, alu_in2=3
  - dest_addr=5, reg_write=1, out_valid=1
- Extension:
  - addi with imm=16'hFFFE -> alu_in2=32'hFFFFFFFE.
  - ori with imm=16'hFFFE -> alu_in2=32'h0000FFFE, alu_op=100101.
- Shift: sra with funct=000011, rt_data=32'h80000000, shamt=4 -> alu_in1=32'h80000000, alu_in2=4, alu_op=000011.
- Stall/flush:
  - lw loaded, then stall=1 for 3 cycles with changing inputs -> outputs unchanged.
  - Then stall=1 and flush=1 together -> bubble loaded (out_valid=0, mem_read=0).
- Illegal and r0:
  - opcode=6'b111111 -> illegal=1, out_valid=0, held through a stall, cleared by the next load.
  - R-type add with rd_addr=0 -> reg_write=0, out_valid=1.
